tick_bcd_counter: RTL and testbench
===================================

# tick_bcd_counter

Downstream consumer of the divided clock. Samples `Div_clk` in the `clk` domain, turns each rising edge into a one-cycle `tick`, and advances a multi-digit BCD counter (up/down, clear, load) on that tick. Sits between the clock divider and the display/segment decode stage; its `bcd` bus is the displayed count.

## Interface
- `DIGITS`, 4, number of BCD digits (1..8); `bcd` width is 4*DIGITS.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `Div_clk`  in  1  divided clock from the clock divider, a registered signal in the `clk` domain; treated as data, never as a clock.
- `en`  in  1  count enable; gates counting only, not `tick`.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `clr`  in  1  synchronous clear to all zeros.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4*DIGITS  value to load; digit i is in bits [4i+3:4i].
- `bcd`  out  4*DIGITS  current count, digit 0 least significant.
- `tick`  out  1  one-cycle pulse per detected `Div_clk` rising edge.
- `wrap`  out  1  one-cycle pulse when a count step wraps (9…9→0…0 up, 0…0→9…9 down).

## Operation
- Edge detect: register `div_q` <= `Div_clk`; edge = `Div_clk` & ~`div_q`. `div_q` resets to 1, so a `Div_clk` already high at reset release gives no edge.
- Priority per cycle: `reset` > `clr` > `load` > count step (edge & `en`).
- `clr`: `bcd` <= 0. `load`: each digit <= min(`load_val` digit, 9); nibbles 10–15 load as 9.
- Count up: digit 0 +1; a digit at 9 becomes 0 and carries to the next. If all digits are 9, the result is all 0 and `wrap` <= 1.
- Count down: digit 0 −1; a digit at 0 becomes 9 and borrows. If all digits are 0, the result is all 9 and `wrap` <= 1.
- `up` is sampled in the step cycle only; a direction change takes effect on the next step.
- `tick` <= edge regardless of `en`, `clr`, or `load`. `wrap` <= 1 only on a count step that wraps, and is never set by `clr` or `load`.
- `bcd` always holds valid BCD; no digit is ever above 9.

## Timing
- Reset values: `bcd` = 0, `tick` = 0, `wrap` = 0, `div_q` = 1.
- Latency: `Div_clk` first sampled high in cycle N (with `div_q` = 0) → `bcd` updated and `tick` = 1 in cycle N+1. `wrap`, when it fires, is high in the same cycle N+1.
- `tick` and `wrap` are high for exactly one cycle per edge. `Div_clk` held high for any length gives one tick.
- Minimum `Div_clk` period is 2 `clk` cycles (1 high, 1 low). Edges at that rate give a tick every 2 cycles, and none are lost.
- `reset` or `clr` asserted in the same cycle as an edge: the count step is dropped, and `bcd` = 0 next cycle. With `clr`, `tick` still pulses; with `reset`, it does not.
- `reset` asserted mid-operation: all outputs return to reset values in the next cycle. The first tick after release needs a fresh 0→1 on `Div_clk`.
- `Div_clk` frequency changes upstream (Div select change) need no handling here; the block only counts edges.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package: `BCD_W` = 4, `BCD_MAX` = 4'd9, default `DIGITS`, and a function that clamps a nibble to 0–9.
- Sub-module `bcd_digit`: combinational, one digit. Inputs: digit, `up`, step_in (carry/borrow in). Outputs: next digit, step_out. Instantiated DIGITS times in a ripple chain with step_in of digit 0 = 1. `wrap` = step_out of the top digit.
- The top level holds all registers: `div_q`, the digit array, `tick`, `wrap`.

## Test plan
- Reset with `Div_clk` = 1, then release → no `tick` and `bcd` = 0000 until `Div_clk` goes 0→1; then `tick` = 1 for exactly one cycle and `bcd` = 0001 (`en` = 1, `up` = 1).
- Load 9998, `en` = 1, `up` = 1, two edges → `bcd` 9999, then 0000 with `wrap` = 1 for one cycle on the second step only.
- Load 0000, `up` = 0, one edge → `bcd` = 9999, `wrap` = 1; a further edge → 9998, `wrap` = 0.
- `en` = 0 with 5 edges → 5 `tick` pulses, `bcd` unchanged at 0042; `load_val` = 16'hFA37 → `bcd` = 9937.
- Same-cycle conflicts: edge with `clr` = 1 → `bcd` = 0000 and `tick` = 1; edge with `load` = 1 (0123) → `bcd` = 0123, no step; `reset` asserted at `bcd` = 0555 → 0000 next cycle, `tick`/`wrap` = 0.
- `Div_clk` toggling every cycle for 20 cycles from 0000, `up` = 1 → 10 ticks, `bcd` = 0010, no missed or double counts.

Source files
------------

// File: rtl/tick_bcd_counter_pkg.sv
// rtl/tick_bcd_counter_pkg.sv - shared BCD widths, limits and nibble clamp
package tick_bcd_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int DEFAULT_DIGITS = 4;

  // Nibbles 10..15 are not valid BCD; they saturate to 9 rather than wrap.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/tick_bcd_counter_digit.sv
// rtl/tick_bcd_counter_digit.sv - combinational single-digit BCD up/down step with carry/borrow
module bcd_digit
  import tick_bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             up_i,
  input  logic             step_in_i,
  output logic [BCD_W-1:0] next_o,
  output logic             step_out_o
);

  always_comb begin
    next_o     = digit_i;
    step_out_o = 1'b0;
    if (step_in_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          next_o     = '0;
          step_out_o = 1'b1;
        end else begin
          next_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          next_o     = BCD_MAX;
          step_out_o = 1'b1;
        end else begin
          next_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - Div_clk rising-edge tick generator driving a multi-digit BCD up/down counter
module tick_bcd_counter
  import tick_bcd_counter_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Div_clk,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    wrap
);

  logic                    div_q;
  logic                    tick_q;
  logic                    wrap_q, wrap_d;
  logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d;
  logic [BCD_W*DIGITS-1:0] stepped;
  logic [BCD_W*DIGITS-1:0] load_clamped;
  logic [DIGITS:0]         step;
  logic                    div_rise;
  logic                    count_step;

  // div_q resets high so a Div_clk already high at release is not an edge.
  assign div_rise   = Div_clk & ~div_q;
  assign count_step = div_rise & en;

  assign step[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i    (bcd_q[g*BCD_W +: BCD_W]),
      .up_i       (up),
      .step_in_i  (step[g]),
      .next_o     (stepped[g*BCD_W +: BCD_W]),
      .step_out_o (step[g+1])
    );
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = clamp_bcd(load_val[i*BCD_W +: BCD_W]);
    end
  end

  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clr) begin
      bcd_d = '0;
    end else if (load) begin
      bcd_d = load_clamped;
    end else if (count_step) begin
      bcd_d  = stepped;
      wrap_d = step[DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 1'b1;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      div_q  <= Div_clk;
      tick_q <= div_rise;
      wrap_q <= wrap_d;
      bcd_q  <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb/tb_tick_bcd_counter.sv - table-driven self-checking bench for tick_bcd_counter
module tb_tick_bcd_counter;

  logic        clk = 1'b0;
  logic        reset, Div_clk, en, up, clr, load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        tick, wrap;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst, dv, en, up, clr, ld;
    logic [15:0] lv;
    logic [15:0] bcd;
    logic        tick, wrap;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  tick_bcd_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .Div_clk  (Div_clk),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .tick     (tick),
    .wrap     (wrap)
  );

  function automatic vec_t mk(input logic r, d, e, u, c, l, input logic [15:0] lv,
                              input logic [15:0] b, input logic t, w);
    vec_t v;
    v.rst = r; v.dv = d; v.en = e; v.up = u; v.clr = c; v.ld = l;
    v.lv = lv; v.bcd = b; v.tick = t; v.wrap = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, d, e, u, c, l, input logic [15:0] lv);
    @(negedge clk);
    reset = r; Div_clk = d; en = e; up = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] b, input logic t, w);
    chk({name, ".bcd"}, {16'h0, bcd}, {16'h0, b});
    chk({name, ".tick"}, {31'h0, tick}, {31'h0, t});
    chk({name, ".wrap"}, {31'h0, wrap}, {31'h0, w});
  endtask

  initial begin
    int ticks;
    reset = 1'b1; Div_clk = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0;

    vecs.push_back(mk(1,1,0,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,0,1,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0001,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0001,0,0));
    vecs.push_back(mk(0,0,1,1,0,1,16'h9998, 16'h9998,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h9999,1,0));
    vecs.push_back(mk(0,0,1,1,0,0,16'h0000, 16'h9999,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0000,1,1));
    vecs.push_back(mk(0,0,1,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,16'h0000, 16'h9999,1,1));
    vecs.push_back(mk(0,0,1,0,0,0,16'h0000, 16'h9999,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,16'h0000, 16'h9998,1,0));
    vecs.push_back(mk(0,0,1,1,0,1,16'h0042, 16'h0042,0,0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0,1,0,1,0,0,16'h0000, 16'h0042,1,0));
      vecs.push_back(mk(0,0,0,1,0,0,16'h0000, 16'h0042,0,0));
    end
    vecs.push_back(mk(0,0,1,1,0,1,16'hFA37, 16'h9937,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,16'h0000, 16'h0000,1,0));
    vecs.push_back(mk(0,0,1,1,0,0,16'h0000, 16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,0,1,16'h0123, 16'h0123,1,0));
    vecs.push_back(mk(0,0,1,1,0,0,16'h0000, 16'h0123,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0124,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0124,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,16'h0000, 16'h0124,0,0));
    vecs.push_back(mk(0,0,1,1,1,1,16'h5555, 16'h0000,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].dv, vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].ld, vecs[i].lv);
      expect_out($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].tick, vecs[i].wrap);
    end

    // Reset mid-operation coincident with an edge, then Div_clk held high after release
    drive(0,0,1,1,0,1,16'h0555);
    expect_out("rst_pre", 16'h0555, 0, 0);
    drive(1,1,1,1,0,0,16'h0000);
    expect_out("rst_edge", 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,1,1,0,0,16'h0000);
      expect_out($sformatf("rst_hold%0d", i), 16'h0000, 0, 0);
    end
    drive(0,0,1,1,0,0,16'h0000);
    expect_out("rst_low", 16'h0000, 0, 0);
    drive(0,1,1,1,0,0,16'h0000);
    expect_out("rst_first", 16'h0001, 1, 0);

    // Div_clk at the fastest legal rate: every edge must count
    drive(0,0,1,1,1,0,16'h0000);
    expect_out("fast_clr", 16'h0000, 0, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, (i % 2 == 0), 1, 1, 0, 0, 16'h0000);
      chk($sformatf("fast_tick%0d", i), {31'h0, tick}, {31'h0, (i % 2 == 0)});
      if (tick) ticks++;
    end
    chk("fast_bcd", {16'h0, bcd}, 32'h0000_0010);
    chk("fast_ticks", ticks, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
